// File: rtl/ff_pkg.sv
// Shared opcode type and helpers for the multi-mode register bank.
package ff_pkg;

    localparam int unsigned OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        HOLD   = 3'd0,
        LOAD   = 3'd1,
        TOGGLE = 3'd2,
        SHR    = 3'd3,
        SHL    = 3'd4,
        ROR    = 3'd5,
        ROL    = 3'd6,
        CLR    = 3'd7
    } op_t;

    // True for the opcodes that advance the shift counter.
    function automatic logic is_shift(input op_t op);
        return (op == SHR) || (op == SHL) || (op == ROR) || (op == ROL);
    endfunction

endpackage

// File: rtl/shift_counter.sv
// Saturating shift counter with a one-cycle pulse on reaching WIDTH.
//   clk, rst : clock, synchronous active-high reset
//   clr      : return count to zero (wins over inc)
//   inc      : one shift/rotate happened this cycle
//   cnt      : shifts since last clear, saturating at WIDTH
//   done     : high for the cycle after cnt steps WIDTH-1 -> WIDTH
module shift_counter #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt,
    output logic             done
);

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    // done is cleared every cycle unless this very increment reaches the top.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (clr) begin
                cnt <= '0;
            end else if (inc && (cnt != CNT_MAX)) begin
                cnt  <= cnt + CNT_W'(1);
                done <= (cnt == CNT_LAST);
            end
        end
    end

endmodule

// File: rtl/param_ff_shift_reg.sv
// WIDTH-bit register bank: hold, load, toggle, shift, rotate and clear,
// with a shift counter so it can serialise a loaded word.
//   clk, rst : clock, synchronous active-high reset
//   en       : operation enable (0 holds everything)
//   op       : opcode (ff_pkg::op_t)
//   d        : parallel load data / toggle mask
//   ser_in   : serial input for SHR/SHL
//   q        : register contents
//   ser_out  : bit shifted/rotated out on the last shift cycle
//   cnt      : shift/rotate count since last LOAD/CLR, saturating
//   done     : single-cycle pulse when cnt reaches WIDTH
module param_ff_shift_reg
    import ff_pkg::*;
#(
    parameter int unsigned           WIDTH   = 8,
    parameter logic [WIDTH-1:0]      RST_VAL = '0,
    localparam int unsigned          CNT_W   = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  op_t              op,
    input  logic [WIDTH-1:0] d,
    input  logic             ser_in,
    output logic [WIDTH-1:0] q,
    output logic             ser_out,
    output logic [CNT_W-1:0] cnt,
    output logic             done
);

    logic [WIDTH-1:0] q_nxt;
    logic             ser_nxt;
    logic             cnt_clr;
    logic             cnt_inc;

    assign cnt_clr = en && ((op == LOAD) || (op == CLR));
    assign cnt_inc = en && is_shift(op);

    // Next-state mux for the data register and serial output.
    always_comb begin
        q_nxt   = q;
        ser_nxt = ser_out;
        if (en) begin
            case (op)
                HOLD:   ;
                LOAD:   q_nxt = d;
                TOGGLE: q_nxt = q ^ d;
                SHR: begin
                    q_nxt   = {ser_in, q[WIDTH-1:1]};
                    ser_nxt = q[0];
                end
                SHL: begin
                    q_nxt   = {q[WIDTH-2:0], ser_in};
                    ser_nxt = q[WIDTH-1];
                end
                ROR: begin
                    q_nxt   = {q[0], q[WIDTH-1:1]};
                    ser_nxt = q[0];
                end
                ROL: begin
                    q_nxt   = {q[WIDTH-2:0], q[WIDTH-1]};
                    ser_nxt = q[WIDTH-1];
                end
                CLR: begin
                    q_nxt   = RST_VAL;
                    ser_nxt = 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q       <= RST_VAL;
            ser_out <= 1'b0;
        end else begin
            q       <= q_nxt;
            ser_out <= ser_nxt;
        end
    end

    shift_counter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_shift_counter (
        .clk  (clk),
        .rst  (rst),
        .clr  (cnt_clr),
        .inc  (cnt_inc),
        .cnt  (cnt),
        .done (done)
    );

endmodule

// File: doc/param_ff_shift_reg.md
Name: param_ff_shift_reg

Overview:
Parametrised WIDTH-bit register bank that generalises the single-bit D/T flip-flop into a multi-mode storage element. Supports hold, D-load, T-toggle, logical shift, rotate and clear, selected per cycle by an opcode. Built-in shift counter raises `done` after WIDTH shift/rotate operations since the last load, so the block can act as a serialiser. Sits in the session datapath library beside the single-bit flip-flops.

Parameters:
WIDTH, 8, register width in bits (>=2)
RST_VAL, 0, value of q after reset and after CLR (WIDTH bits)
CNT_W, $clog2(WIDTH+1), width of shift counter (derived, not overridden)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
en  input  1  operation enable; 0 forces HOLD
op  input  3  opcode (see Behaviour)
d  input  WIDTH  parallel load data / toggle mask
ser_in  input  1  serial input for shifts
q  output  WIDTH  register contents
ser_out  output  1  bit shifted out on the last shift cycle (registered)
cnt  output  CNT_W  shift/rotate operations since last LOAD/CLR, saturating at WIDTH
done  output  1  single-cycle pulse when cnt transitions WIDTH-1 -> WIDTH

Behaviour:
- All state updates on posedge clk. rst is sampled synchronously and has top priority over en and op.
- Reset values: q=RST_VAL, ser_out=0, cnt=0, done=0.
- Opcodes, applied only when en=1:
  - 0 HOLD: no change.
  - 1 LOAD: q<=d; cnt<=0.
  - 2 TOGGLE: q<=q^d; cnt unchanged.
  - 3 SHR: q<={ser_in,q[W-1:1]}; ser_out<=q[0].
  - 4 SHL: q<={q[W-2:0],ser_in}; ser_out<=q[W-1].
  - 5 ROR: q<={q[0],q[W-1:1]}; ser_out<=q[0].
  - 6 ROL: q<={q[W-2:0],q[W-1]}; ser_out<=q[W-1].
  - 7 CLR: q<=RST_VAL; cnt<=0; ser_out<=0.
- ser_out holds its value on all ops except 3-7.
- cnt increments by 1 on ops 3-6 while cnt<WIDTH. It saturates at WIDTH; further shifts leave it at WIDTH.
- done=1 for exactly the cycle after the shift that makes cnt==WIDTH; otherwise 0. It does not re-fire while saturated.
- en=0: every register holds and done=0.
- Latency: one cycle from op sample to q/ser_out/cnt update. Outputs are purely registered; there are no combinational paths from inputs to outputs.
- Reset mid-sequence (rst=1 with any op) restores reset values; done is suppressed that cycle.
- LOAD and CLR in the same cycle that cnt would reach WIDTH: LOAD/CLR wins, so cnt=0 and done=0.
- TOGGLE with d=0 is equivalent to HOLD.

Decomposition:
- Package ff_pkg holds:
  - `op_t` enum, 3 bits: HOLD, LOAD, TOGGLE, SHR, SHL, ROR, ROL, CLR.
  - Constant OP_W=3.
  - Function `is_shift(op_t)`.
- One sub-module, shift_counter: saturating CNT_W counter with clear, increment and done-pulse logic.
- The main module contains the q/ser_out next-state mux.

Test Plan:
- Reset: rst=1 for 2 cycles with op=LOAD, d=8'hFF -> q=8'h00, cnt=0, done=0; rst release -> values held with op=HOLD.
- LOAD then TOGGLE: LOAD d=8'hA5 -> q=8'hA5; TOGGLE d=8'h0F -> q=8'hAA; TOGGLE d=0 -> q=8'hAA.
- Serialiser: LOAD 8'hB4, then 8 SHR with ser_in=0 -> ser_out sequence 0,0,1,0,1,1,0,1, cnt 1..8, done high exactly on the 8th, q=8'h00; 9th SHR -> cnt stays 8, done=0.
- Rotate: LOAD 8'h81; ROL -> 8'h03; ROR x2 -> 8'hC0; 8 ROL from 8'h81 -> q=8'h81 and done pulses once.
- Enable and collision:
  - en=0 with op=SHL for 3 cycles -> q and cnt unchanged.
  - At cnt=7, issue LOAD 8'h11 -> cnt=0, done=0, q=8'h11.
- Reset mid-shift: after 5 SHL, rst=1 with op=SHL -> q=RST_VAL, cnt=0, ser_out=0, no done.
- Every check is compared against a behavioural golden model each negedge and reported pass/fail.
